serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 1..32.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand set a/b/cin is valid.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 a  input  WIDTH  operand A, unsigned.
REQ-007 b  input  WIDTH  operand B, unsigned.
REQ-008 cin  input  1  carry-in.
REQ-009 out_valid  output  1  sum/cout are valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 sum  output  WIDTH  result bits.
REQ-012 cout  output  1  final carry-out.
REQ-013 busy  output  1  high in RUN or DONE.

Function
REQ-014 The block shall instantiate exactly one fadder, with 3-bit input a[0:2] and outputs s and c.
REQ-015 The fadder input mapping shall be a[0]=current A bit, a[1]=current B bit, a[2]=carry register; no other adder logic is permitted.
REQ-016 The FSM shall have three states: IDLE, RUN and DONE.
REQ-017 In IDLE, in_ready=1; all other states drive in_ready=0.
REQ-018 On an edge with in_valid&&in_ready, the block shall capture a and b into shift registers, load the carry register with cin, clear the bit index, and enter RUN.
REQ-019 In RUN, bit idx shall be processed LSB first, one bit per cycle.
REQ-020 At each RUN edge, fadder.s shall be shifted into the MSB of the sum register, which shifts right, and fadder.c shall be written into the carry register.
REQ-021 At the RUN edge where idx==WIDTH-1, the FSM shall enter DONE.
REQ-022 The bit index shall be ceil(log2(WIDTH+1)) bits wide and shall never wrap past WIDTH-1.
REQ-023 Latency: out_valid shall rise exactly WIDTH cycles after the accepting edge (WIDTH=1 gives 1 cycle).
REQ-024 In DONE, out_valid=1; sum equals (a+b+cin) mod 2^WIDTH, and cout equals bit WIDTH of (a+b+cin).
REQ-025 sum, cout and out_valid shall hold stable while out_ready=0, with no timeout.
REQ-026 On an edge with out_valid&&out_ready, the FSM shall return to IDLE and out_valid shall fall.
REQ-027 in_ready shall rise in the cycle after the output handshake, so a new operand set is accepted no earlier than one cycle after that handshake.
REQ-028 in_valid, a, b and cin shall be ignored in RUN and DONE; captured operands are not disturbed by input changes.
REQ-029 sum and cout shall be don't-care-free: they are driven from registers in every state and read as 0 until the first completion.
REQ-030 busy shall equal (state!=IDLE).

Reset
REQ-031 While rst_n=0 at a rising edge, the state shall go to IDLE and all of these shall clear to 0: shift registers, sum register, carry register, idx, out_valid and cout.
REQ-032 Reset values: in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
REQ-033 Reset asserted mid-RUN or in DONE shall discard the operation with no output handshake.
REQ-034 The first acceptance shall be possible at the first edge with rst_n=1 and in_valid=1.
REQ-035 rst_n takes priority over every handshake occurring at the same edge.

Verification (WIDTH=8)
REQ-036 a=0x00, b=0x00, cin=0, out_ready=1 -> 8 cycles after acceptance: out_valid=1, sum=0x00, cout=0.
REQ-037 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; busy=1 from the acceptance edge through the output handshake.
REQ-038 a=0xA5, b=0x5A, cin=1 with out_ready=0 for 5 cycles after out_valid -> sum=0x00 and cout=1 held stable, and in_ready=0 throughout; after out_ready=1, in_ready=1 on the next cycle.
REQ-039 a=0x3C, b=0x0F, cin=0 accepted, then in_valid=1 with a=0xFF during RUN -> result sum=0x4B, cout=0; the second set is accepted only after return to IDLE.
REQ-040 rst_n=0 for one edge while processing bit 3 -> next cycle: in_ready=1, out_valid=0, sum=0x00, cout=0; no out_valid pulse appears for the aborted operation.
REQ-041 WIDTH=1 build, a=1, b=1, cin=1 -> out_valid one cycle after acceptance, with sum=1, cout=1.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: captures an operand set, adds it LSB-first through
// a single full adder, one bit per clock, and holds the result until it is taken.

module fadder (
  input  logic [0:2] a,
  output logic       s,
  output logic       c
);
  assign s = ^a;
  assign c = (a[0] & a[1]) | (a[0] & a[2]) | (a[1] & a[2]);
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int unsigned IDXW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sh, sum_q, sum_shift_nxt;
  logic             carry_q, cout_q;
  logic [IDXW-1:0]  idx;
  logic [0:2]       fa_in;
  logic             fa_s, fa_c;
  logic             last_bit;

  assign fa_in    = {a_sr[0], b_sr[0], carry_q};
  assign last_bit = (idx == IDXW'(WIDTH - 1));

  fadder u_fadder (
    .a (fa_in),
    .s (fa_s),
    .c (fa_c)
  );

  always_comb begin
    sum_shift_nxt            = sum_sh >> 1;
    sum_shift_nxt[WIDTH-1]   = fa_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // The working sum register shifts during RUN; the visible result is copied
  // out only on the final bit so sum/cout never show partial values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sh  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr    <= a;
            b_sr    <= b;
            carry_q <= cin;
            idx     <= '0;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          sum_sh  <= sum_shift_nxt;
          carry_q <= fa_c;
          if (last_bit) begin
            sum_q  <= sum_shift_nxt;
            cout_q <= fa_c;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: directed cases plus randomized traffic
// with random output backpressure, checked against plain integer addition.

module tb_serial_add_ctrl;
  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           acc_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  logic in_valid1 = 1'b0, in_ready1, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
  logic out_valid1, sum1, cout1, busy1;

  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;
  exp_t q[$];
  bit   rand_bp = 1'b0;
  bit   force_ready = 1'b1;

  logic         prev_ov = 1'b0;
  logic [W-1:0] prev_sum = '0;
  logic         prev_cout = 1'b0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(1'b1),
    .sum(sum1), .cout(cout1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial out_ready = 1'b1;
  always @(posedge clk) begin
    #1 out_ready = rand_bp ? 1'($urandom_range(0, 1)) : force_ready;
  end

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Drives an operand set (call just after a rising edge) and holds it until accepted.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    logic [W:0] total;
    bit         ok = 1'b0;
    in_valid = 1'b1; a = av; b = bv; cin = cv;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept_timeout", 0, 1);
    else begin
      total = (W+1)'(av) + (W+1)'(bv) + (W+1)'(cv);
      q.push_back('{sum: total[W-1:0], cout: total[W], acc_cyc: cycle + 1});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (in_ready && q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) check("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  // Monitor: latency on rising out_valid, hold stability, and result on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) prev_ov = 1'b0;
    else begin
      if (out_valid && !prev_ov) begin
        if (q.size() == 0) check("spurious_out_valid", 1, 0);
        else check("latency", cycle - q[0].acc_cyc, W);
      end
      if (out_valid && prev_ov) begin
        check("hold_sum", sum, prev_sum);
        check("hold_cout", cout, prev_cout);
      end
      if (out_valid && out_ready && q.size() != 0) begin
        e = q.pop_front();
        check("sum", sum, e.sum);
        check("cout", cout, e.cout);
      end
      prev_ov = out_valid; prev_sum = sum; prev_cout = cout;
    end
  end

  initial begin
    bit seen;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);

    // First edge with rst_n=1 must accept.
    @(posedge clk); #1 rst_n = 1'b1;
    send(8'h00, 8'h00, 1'b0);
    wait_idle();

    send(8'hFF, 8'h01, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("busy_during_op", busy, 1);
      if (out_valid && out_ready) begin seen = 1'b1; break; end
    end
    if (!seen) check("handshake_timeout", 0, 1);
    @(negedge clk);
    check("busy_after_hs", busy, 0);
    check("in_ready_after_hs", in_ready, 1);
    wait_idle();

    // Backpressure hold.
    force_ready = 1'b0;
    @(posedge clk); #1;
    send(8'hA5, 8'h5A, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    if (!seen) check("valid_timeout", 0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_sum", sum, 8'h00);
      check("bp_cout", cout, 1);
    end
    force_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_ready", out_ready, 1);
    check("bp_in_ready_pre", in_ready, 0);
    @(negedge clk);
    check("bp_in_ready_post", in_ready, 1);
    wait_idle();

    // A second set offered during RUN waits for IDLE.
    send(8'h3C, 8'h0F, 1'b0);
    send(8'hFF, 8'h00, 1'b0);
    wait_idle();

    // Reset while bit 3 is being processed.
    send(8'h77, 8'h99, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_valid", out_valid, 0);
    end
    @(posedge clk); #1;

    // Random traffic with random backpressure.
    rand_bp = 1'b1;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1 send(W'($urandom), W'($urandom), 1'($urandom));
    end
    wait_idle();
    rand_bp = 1'b0;

    // WIDTH=1 instance.
    @(posedge clk); #1;
    in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    @(negedge clk);
    check("w1_in_ready", in_ready1, 1);
    @(posedge clk); #1 in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    @(negedge clk);
    check("w1_not_yet", out_valid1, 0);
    @(negedge clk);
    check("w1_out_valid", out_valid1, 1);
    check("w1_sum", sum1, 1);
    check("w1_cout", cout1, 1);

    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
